// File: rtl/mem_xbar_if.sv
// Bus bundle for the 2-master (instr/data) to NSLV-slave memory crossbar.
// The slave modport is the crossbar's view; master is the surrounding cpu/slave environment.
interface mem_xbar_if #(
  parameter int NSLV = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  localparam int SW = DW / 8;

  logic              i_valid;
  logic              i_instr;
  logic [AW-1:0]     i_addr;
  logic [DW-1:0]     i_wdata;
  logic [SW-1:0]     i_wstrb;
  logic [DW-1:0]     i_rdata;
  logic              i_ready;
  logic              i_err;

  logic              d_valid;
  logic              d_instr;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wdata;
  logic [SW-1:0]     d_wstrb;
  logic [DW-1:0]     d_rdata;
  logic              d_ready;
  logic              d_err;

  logic [NSLV-1:0]    s_valid;
  logic [NSLV-1:0]    s_instr;
  logic [NSLV*AW-1:0] s_addr;
  logic [NSLV*DW-1:0] s_wdata;
  logic [NSLV*SW-1:0] s_wstrb;
  logic [NSLV*DW-1:0] s_rdata;
  logic [NSLV-1:0]    s_ready;

  // Debug view of per-slave ownership (2 bits each: 0 free, 1 I, 2 D) and priority (1 = D next).
  logic [2*NSLV-1:0]  owner_dbg;
  logic [NSLV-1:0]    prio_dbg;

  // Handshake: a master raises valid with a stable payload and holds both until its one-cycle
  // ready pulse; ready is asserted only by the slave it owns, or by the unmapped-address error path.
  modport slave (
    input  i_valid, i_instr, i_addr, i_wdata, i_wstrb,
    output i_rdata, i_ready, i_err,
    input  d_valid, d_instr, d_addr, d_wdata, d_wstrb,
    output d_rdata, d_ready, d_err,
    output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    input  s_rdata, s_ready,
    output owner_dbg, prio_dbg
  );

  modport master (
    output i_valid, i_instr, i_addr, i_wdata, i_wstrb,
    input  i_rdata, i_ready, i_err,
    output d_valid, d_instr, d_addr, d_wdata, d_wstrb,
    input  d_rdata, d_ready, d_err,
    input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    output s_rdata, s_ready,
    input  owner_dbg, prio_dbg
  );
endinterface

// File: rtl/mem_xbar.sv
// Instr/data master to NSLV-slave crossbar: window decode, per-slave ownership with
// round-robin arbitration on conflicts, and a one-cycle error response for unmapped addresses.
module mem_xbar #(
  parameter int               NSLV     = 4,
  parameter int               AW       = 32,
  parameter int               DW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_TOP  = '0
) (
  input  logic       clk,
  input  logic       rst,
  mem_xbar_if.slave  bus
);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    OWN_FREE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t          owner_q [NSLV];
  logic [NSLV-1:0] prio_q;      // 1: D wins the next conflict, 0: I wins
  logic            i_err_q;
  logic            d_err_q;

  logic [NSLV-1:0] i_hit, d_hit;
  logic [NSLV-1:0] i_req, d_req;
  logic            i_unmapped, d_unmapped;
  logic [NSLV-1:0] grant_i, grant_d;

  // One-hot hit vector; the lowest-numbered window wins on overlap.
  function automatic logic [NSLV-1:0] decode(input logic [AW-1:0] a);
    logic [NSLV-1:0] h;
    logic            found;
    h     = '0;
    found = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (!found && (a >= SLV_BASE[k*AW +: AW]) && (a < SLV_TOP[k*AW +: AW])) begin
        h[k]  = 1'b1;
        found = 1'b1;
      end
    end
    return h;
  endfunction

  assign i_hit      = decode(bus.i_addr);
  assign d_hit      = decode(bus.d_addr);
  assign i_req      = bus.i_valid ? i_hit : '0;
  assign d_req      = bus.d_valid ? d_hit : '0;
  assign i_unmapped = bus.i_valid && (i_hit == '0);
  assign d_unmapped = bus.d_valid && (d_hit == '0);

  always_comb begin
    grant_i     = '0;
    grant_d     = '0;
    bus.s_valid = '0;
    bus.s_instr = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    bus.i_ready = i_err_q;
    bus.i_err   = i_err_q;
    bus.i_rdata = '0;
    bus.d_ready = d_err_q;
    bus.d_err   = d_err_q;
    bus.d_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (owner_q[k] == OWN_FREE) begin
        grant_i[k] = i_req[k] && (!d_req[k] || !prio_q[k]);
        grant_d[k] = d_req[k] && (!i_req[k] ||  prio_q[k]);
      end
      if (owner_q[k] == OWN_I || grant_i[k]) begin
        bus.s_valid[k]           = bus.i_valid;
        bus.s_instr[k]           = bus.i_instr;
        bus.s_addr[k*AW +: AW]   = bus.i_addr - SLV_BASE[k*AW +: AW];
        bus.s_wdata[k*DW +: DW]  = bus.i_wdata;
        bus.s_wstrb[k*SW +: SW]  = bus.i_wstrb;
      end else if (owner_q[k] == OWN_D || grant_d[k]) begin
        bus.s_valid[k]           = bus.d_valid;
        bus.s_instr[k]           = bus.d_instr;
        bus.s_addr[k*AW +: AW]   = bus.d_addr - SLV_BASE[k*AW +: AW];
        bus.s_wdata[k*DW +: DW]  = bus.d_wdata;
        bus.s_wstrb[k*SW +: SW]  = bus.d_wstrb;
      end
      // A slave's ready is only routed back to the master that owns it.
      if (owner_q[k] == OWN_I && bus.s_ready[k]) begin
        bus.i_ready = 1'b1;
        bus.i_rdata = bus.i_rdata | bus.s_rdata[k*DW +: DW];
      end
      if (owner_q[k] == OWN_D && bus.s_ready[k]) begin
        bus.d_ready = 1'b1;
        bus.d_rdata = bus.d_rdata | bus.s_rdata[k*DW +: DW];
      end
    end
    // Outputs are forced low for the whole reset interval, not just from the next edge.
    if (!rst) begin
      bus.s_valid = '0;
      bus.s_instr = '0;
      bus.s_addr  = '0;
      bus.s_wdata = '0;
      bus.s_wstrb = '0;
      bus.i_ready = 1'b0;
      bus.i_err   = 1'b0;
      bus.i_rdata = '0;
      bus.d_ready = 1'b0;
      bus.d_err   = 1'b0;
      bus.d_rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NSLV; k++) owner_q[k] <= OWN_FREE;
      prio_q  <= '1;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      // The held request would re-trigger in its own response cycle, so the flop self-clears.
      i_err_q <= i_unmapped && !i_err_q;
      d_err_q <= d_unmapped && !d_err_q;
      for (int k = 0; k < NSLV; k++) begin
        case (owner_q[k])
          OWN_FREE: begin
            if (grant_i[k])      owner_q[k] <= OWN_I;
            else if (grant_d[k]) owner_q[k] <= OWN_D;
            if (i_req[k] && d_req[k]) prio_q[k] <= ~prio_q[k];
          end
          default: begin
            if (bus.s_ready[k]) owner_q[k] <= OWN_FREE;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < NSLV; k++) begin : g_dbg
    assign bus.owner_dbg[2*k +: 2] = owner_q[k];

    // An owning master must keep its request up until the slave answers.
    a_i_hold: assert property (@(posedge clk) disable iff (!rst) (owner_q[k] == OWN_I) |-> bus.i_valid);
    a_d_hold: assert property (@(posedge clk) disable iff (!rst) (owner_q[k] == OWN_D) |-> bus.d_valid);
  end
  assign bus.prio_dbg = prio_q;

endmodule
